// File: rtl/seq_ripple_adder.sv
// Multi-cycle N-bit adder: one DIGIT-bit ripple slice per clock, with the carry
// registered between slices. Start/busy/done handshake with registered sum/cout/ovf.
module seq_ripple_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSL = (DIGIT > 0) ? WIDTH / DIGIT : 1;
    localparam int KW  = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [KW-1:0] KLAST = KW'(NSL - 1);

    generate
        if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("seq_ripple_adder: WIDTH must be >= 2 and DIGIT must divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] opa, opb, acc, acc_nxt;
    logic             carry;
    logic [KW-1:0]    k;
    logic [DIGIT-1:0] sa, sb, ss;
    logic             cy, cmsb;
    int               base;
    logic             accept, last;

    // Operands are only taken when no slice work is in flight.
    assign accept = start && (state != RUN);
    assign last   = (k == KLAST);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Slice adder: DIGIT full-adder cells rippling from the registered carry.
    always_comb begin
        base    = int'(k) * DIGIT;
        sa      = opa[base +: DIGIT];
        sb      = opb[base +: DIGIT];
        ss      = '0;
        cy      = carry;
        cmsb    = 1'b0;
        for (int i = 0; i < DIGIT; i++) begin
            ss[i] = sa[i] ^ sb[i] ^ cy;
            if (i == DIGIT - 1) cmsb = cy;
            cy = (sa[i] & sb[i]) | (sb[i] & cy) | (sa[i] & cy);
        end
        acc_nxt              = acc;
        acc_nxt[base +: DIGIT] = ss;
    end

    // The last slice carries straight into the visible result registers, so the
    // partial accumulator never reaches sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            opa   <= '0;
            opb   <= '0;
            acc   <= '0;
            carry <= 1'b0;
            k     <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            opa   <= a;
            opb   <= b;
            carry <= cin;
            k     <= '0;
        end else if (state == RUN) begin
            acc   <= acc_nxt;
            carry <= cy;
            k     <= k + KW'(1);
            if (last) begin
                sum  <= acc_nxt;
                cout <= cy;
                ovf  <= cy ^ cmsb;
            end
        end
    end

endmodule

// File: tb/tb_seq_ripple_adder.sv
// Self-checking bench for seq_ripple_adder: three instances (8/1, 8/4, 8/8) driven
// with directed and random operands, checked against an arithmetic reference.
module tb_seq_ripple_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       s  [3];
    logic [7:0] av [3];
    logic [7:0] bv [3];
    logic       cv [3];
    logic       bz [3];
    logic       dn [3];
    logic [7:0] sm [3];
    logic       co [3];
    logic       ov [3];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seq_ripple_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .rst(rst), .start(s[0]), .a(av[0]), .b(bv[0]), .cin(cv[0]),
        .busy(bz[0]), .done(dn[0]), .sum(sm[0]), .cout(co[0]), .ovf(ov[0]));
    seq_ripple_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
        .clk(clk), .rst(rst), .start(s[1]), .a(av[1]), .b(bv[1]), .cin(cv[1]),
        .busy(bz[1]), .done(dn[1]), .sum(sm[1]), .cout(co[1]), .ovf(ov[1]));
    seq_ripple_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (
        .clk(clk), .rst(rst), .start(s[2]), .a(av[2]), .b(bv[2]), .cin(cv[2]),
        .busy(bz[2]), .done(dn[2]), .sum(sm[2]), .cout(co[2]), .ovf(ov[2]));

    // Reference: {ovf, cout, sum} from plain integer addition and sign rules.
    function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic c);
        logic [8:0] full;
        logic       o;
        full = {1'b0, x} + {1'b0, y} + {8'd0, c};
        o    = (x[7] == y[7]) && (full[7] != x[7]);
        return {o, full[8], full[7:0]};
    endfunction

    function automatic int nslices(input int inst);
        return (inst == 0) ? 8 : (inst == 1) ? 2 : 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input int inst, input logic [7:0] x, input logic [7:0] y,
                                input logic c, input string tag);
        logic [9:0] e;
        e = model(x, y, c);
        check({tag, ".done"}, 32'(dn[inst]), 32'd1);
        check({tag, ".busy_in_done"}, 32'(bz[inst]), 32'd0);
        check({tag, ".sum"}, 32'(sm[inst]), 32'(e[7:0]));
        check({tag, ".cout"}, 32'(co[inst]), 32'(e[8]));
        check({tag, ".ovf"}, 32'(ov[inst]), 32'(e[9]));
    endtask

    // One full operation; operands are scrambled while busy to prove capture.
    task automatic run_op(input int inst, input logic [7:0] x, input logic [7:0] y,
                          input logic c, input string tag);
        s[inst]  = 1'b1;
        av[inst] = x;
        bv[inst] = y;
        cv[inst] = c;
        step();
        s[inst] = 1'b0;
        for (int i = 0; i < nslices(inst); i++) begin
            check({tag, ".busy"}, 32'(bz[inst]), 32'd1);
            check({tag, ".no_early_done"}, 32'(dn[inst]), 32'd0);
            av[inst] = 8'($urandom);
            bv[inst] = 8'($urandom);
            cv[inst] = 1'($urandom);
            step();
        end
        check_result(inst, x, y, c, tag);
        step();
        check({tag, ".done_one_cycle"}, 32'(dn[inst]), 32'd0);
        check({tag, ".sum_held"}, 32'(sm[inst]), 32'(model(x, y, c) & 10'h0FF));
    endtask

    initial begin
        logic [7:0] ea, eb;
        logic       ec;
        int         npulse;
        int         inst;

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s[i] = 1'b1; av[i] = 8'hFF; bv[i] = 8'hFF; cv[i] = 1'b1;
        end
        step();
        step();
        // start together with rst must not be accepted
        check("rst_start.busy", 32'(bz[0]), 32'd0);
        check("rst.done", 32'(dn[0]), 32'd0);
        check("rst.sum", 32'(sm[0]), 32'd0);
        check("rst.cout", 32'(co[0]), 32'd0);
        check("rst.ovf", 32'(ov[0]), 32'd0);
        check("rst.busy_d4", 32'(bz[1]), 32'd0);
        for (int i = 0; i < 3; i++) s[i] = 1'b0;
        rst = 1'b0;
        step();
        check("idle.busy", 32'(bz[0]), 32'd0);

        run_op(0, 8'h5A, 8'h3C, 1'b0, "t1");
        run_op(0, 8'hFF, 8'h01, 1'b0, "t2a");
        run_op(0, 8'h7F, 8'h00, 1'b1, "t2b");
        run_op(1, 8'hFF, 8'hFF, 1'b1, "t3");
        run_op(2, 8'h80, 8'h80, 1'b0, "w_eq_d");

        // start and operand changes while busy are ignored
        s[0] = 1'b1; av[0] = 8'h5A; bv[0] = 8'h3C; cv[0] = 1'b0;
        step();
        s[0] = 1'b0;
        step();
        step();
        s[0] = 1'b1; av[0] = 8'h11; bv[0] = 8'h22;
        step();
        av[0] = ~av[0]; bv[0] = ~bv[0];
        step();
        s[0] = 1'b0;
        npulse = 0;
        for (int i = 0; i < 12; i++) begin
            if (dn[0]) begin
                npulse++;
                check("t4.sum", 32'(sm[0]), 32'h96);
            end
            step();
        end
        check("t4.done_pulses", 32'(npulse), 32'd1);

        // start held high: back-to-back operations every 9 cycles
        s[0] = 1'b1;
        ea = 8'($urandom); eb = 8'($urandom); ec = 1'($urandom);
        av[0] = ea; bv[0] = eb; cv[0] = ec;
        for (int r = 0; r < 5; r++) begin
            step();
            for (int i = 0; i < 8; i++) begin
                check("t5.busy", 32'(bz[0]), 32'd1);
                av[0] = 8'($urandom); bv[0] = 8'($urandom); cv[0] = 1'($urandom);
                step();
            end
            check_result(0, ea, eb, ec, "t5");
            ea = 8'($urandom); eb = 8'($urandom); ec = 1'($urandom);
            av[0] = ea; bv[0] = eb; cv[0] = ec;
        end
        s[0] = 1'b0;
        step();
        step();

        // reset in the middle of a run
        run_op(0, 8'h5A, 8'h3C, 1'b0, "t6pre");
        s[0] = 1'b1; av[0] = 8'h12; bv[0] = 8'h34; cv[0] = 1'b1;
        step();
        s[0] = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6.busy", 32'(bz[0]), 32'd0);
        check("t6.done", 32'(dn[0]), 32'd0);
        check("t6.sum", 32'(sm[0]), 32'd0);
        check("t6.cout", 32'(co[0]), 32'd0);
        check("t6.ovf", 32'(ov[0]), 32'd0);
        npulse = 0;
        for (int i = 0; i < 12; i++) begin
            if (dn[0] || bz[0]) npulse++;
            step();
        end
        check("t6.no_done_after_rst", 32'(npulse), 32'd0);
        run_op(0, 8'hC3, 8'h4E, 1'b1, "t6post");

        for (int r = 0; r < 20; r++) begin
            inst = int'($urandom_range(0, 2));
            run_op(inst, 8'($urandom), 8'($urandom), 1'($urandom), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
